// File: rtl/hamming_rx_corrector.sv
// Serial Hamming(7,4) receiver: deserialises codewords b[0] first, computes the
// syndrome, optionally corrects a single-bit error and presents one nibble at a time.
module hamming_rx_corrector #(
    parameter int CNT_W      = 8,
    parameter int CORRECT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             ser_valid,
    input  logic             ser_bit,
    output logic             ser_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic [2:0]       out_syn,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] bit_cnt_p0;
    logic [5:0] hold_p0;
    logic       accept;
    logic       complete;
    logic [6:0] cw;
    logic [2:0] syn;
    logic [3:0] data;
    logic       cnt_inc;

    function automatic logic [2:0] syndrome(input logic [6:0] b);
        logic s1, s2, s4;
        s1 = b[0] ^ b[2] ^ b[4] ^ b[6];
        s2 = b[1] ^ b[2] ^ b[5] ^ b[6];
        s4 = b[3] ^ b[4] ^ b[5] ^ b[6];
        return {s4, s2, s1};
    endfunction

    function automatic logic [3:0] extract(input logic [6:0] b, input logic [2:0] s);
        logic [6:0] f;
        f = b;
        if (CORRECT_EN != 0 && s != 3'd0)
            f[s - 3'd1] = ~f[s - 3'd1];
        return {f[6], f[5], f[4], f[2]};
    endfunction

    // The last bit only stalls when the single-entry output stage cannot take its result.
    assign ser_ready = !(bit_cnt_p0 == 3'd6 && out_valid && !out_ready);
    assign accept    = ser_valid && ser_ready;
    assign complete  = accept && !sync && bit_cnt_p0 == 3'd6;
    assign cw        = {ser_bit, hold_p0};
    assign syn       = syndrome(cw);
    assign data      = extract(cw, syn);
    assign cnt_inc   = complete && syn != 3'd0;

    // Stage p0: bit counter and holding register; new bits enter at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_p0 <= 3'd0;
            hold_p0    <= 6'd0;
        end else if (sync) begin
            if (accept) begin
                bit_cnt_p0 <= 3'd1;
                hold_p0    <= {ser_bit, 5'd0};
            end else begin
                bit_cnt_p0 <= 3'd0;
                hold_p0    <= 6'd0;
            end
        end else if (accept) begin
            if (bit_cnt_p0 == 3'd6) begin
                bit_cnt_p0 <= 3'd0;
                hold_p0    <= 6'd0;
            end else begin
                bit_cnt_p0 <= bit_cnt_p0 + 3'd1;
                hold_p0    <= {ser_bit, hold_p0[5:1]};
            end
        end
    end

    // Stage p1: output register; a load may coincide with a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            out_err   <= 1'b0;
            out_syn   <= 3'd0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= data;
            out_err   <= syn != 3'd0;
            out_syn   <= syn;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (clr_cnt)
            err_cnt <= cnt_inc ? CNT_W'(1) : '0;
        else if (cnt_inc && err_cnt != CNT_MAX)
            err_cnt <= err_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hamming_rx_corrector.sv
// Directed bench: a correcting DUT (CNT_W=8) and a detect-only DUT (CNT_W=2) share stimulus.
module tb_hamming_rx_corrector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync = 1'b0;
    logic       ser_valid = 1'b0;
    logic       ser_bit = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_cnt = 1'b0;
    logic       ser_ready, out_valid, out_err;
    logic [3:0] out_data;
    logic [2:0] out_syn;
    logic [7:0] err_cnt;
    logic       ser_ready2, out_valid2, out_err2;
    logic [3:0] out_data2;
    logic [2:0] out_syn2;
    logic [1:0] err_cnt2;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    int exp_cnt2 = 0;

    always #5 clk = ~clk;

    hamming_rx_corrector #(.CNT_W(8), .CORRECT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .ser_valid(ser_valid), .ser_bit(ser_bit),
        .ser_ready(ser_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .out_syn(out_syn),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );

    hamming_rx_corrector #(.CNT_W(2), .CORRECT_EN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .ser_valid(ser_valid), .ser_bit(ser_bit),
        .ser_ready(ser_ready2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_err(out_err2), .out_syn(out_syn2),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
    );

    typedef struct {
        logic [6:0] cw;
        logic [3:0] data;
        logic [3:0] raw;
        logic       err;
        logic [2:0] syn;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic clr);
        int t;
        t = 0;
        ser_valid = 1'b1;
        ser_bit   = b;
        while (!ser_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("ser_ready_timeout", 32'(ser_ready), 32'd1);
        clr_cnt = clr;
        tick();
        ser_valid = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic send_cw(input logic [6:0] cw, input logic clr_last);
        for (int i = 0; i < 7; i++) send_bit(cw[i], (i == 6) ? clr_last : 1'b0);
    endtask

    initial begin
        vecs[0] = '{7'b1010101, 4'b1011, 4'b1011, 1'b0, 3'd0};
        vecs[1] = '{7'b1000101, 4'b1011, 4'b1001, 1'b1, 3'd5};
        vecs[2] = '{7'b0000000, 4'b0000, 4'b0000, 1'b0, 3'd0};
        vecs[3] = '{7'b1111111, 4'b1111, 4'b1111, 1'b0, 3'd0};
        vecs[4] = '{7'b1010100, 4'b1011, 4'b1011, 1'b1, 3'd1};
        vecs[5] = '{7'b0010101, 4'b1011, 4'b0011, 1'b1, 3'd7};
        vecs[6] = '{7'b1010001, 4'b1011, 4'b1010, 1'b1, 3'd3};
        vecs[7] = '{7'b0110011, 4'b0110, 4'b0110, 1'b0, 3'd0};
        vecs[8] = '{7'b0010011, 4'b0110, 4'b0010, 1'b1, 3'd6};

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_syn", 32'(out_syn), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_ser_ready", 32'(ser_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Table of single codewords, consumer always ready
        for (int v = 0; v < 9; v++) begin
            send_cw(vecs[v].cw, 1'b0);
            if (vecs[v].err) begin
                exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            chk($sformatf("v%0d_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_data", v), 32'(out_data), 32'(vecs[v].data));
            chk($sformatf("v%0d_err", v), 32'(out_err), 32'(vecs[v].err));
            chk($sformatf("v%0d_syn", v), 32'(out_syn), 32'(vecs[v].syn));
            chk($sformatf("v%0d_cnt", v), 32'(err_cnt), 32'(exp_cnt));
            chk($sformatf("v%0d_raw_data", v), 32'(out_data2), 32'(vecs[v].raw));
            chk($sformatf("v%0d_cnt2", v), 32'(err_cnt2), 32'(exp_cnt2));
            tick();
            chk($sformatf("v%0d_drained", v), 32'(out_valid), 32'd0);
        end

        // Back-pressure: second codeword stalls at bit 6, loads as the first drains
        out_ready = 1'b0;
        send_cw(7'b1010101, 1'b0);
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 6; i++) send_bit(vecs[7].cw[i], 1'b0);
        chk("bp_hold_data", 32'(out_data), 32'b1011);
        ser_valid = 1'b1;
        ser_bit   = vecs[7].cw[6];
        #1;
        chk("bp_ser_ready_low", 32'(ser_ready), 32'd0);
        tick();
        tick();
        chk("bp_still_valid", 32'(out_valid), 32'd1);
        chk("bp_still_data", 32'(out_data), 32'b1011);
        chk("bp_still_ready_low", 32'(ser_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_high", 32'(ser_ready), 32'd1);
        tick();
        ser_valid = 1'b0;
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_data", 32'(out_data), 32'b0110);
        tick();
        chk("bp_second_drained", 32'(out_valid), 32'd0);

        // Sync realigns: three stray bits are discarded
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        sync = 1'b1;
        send_bit(1'b0, 1'b0);
        sync = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
        chk("sync_no_early_valid", 32'(out_valid), 32'd0);
        send_bit(1'b0, 1'b0);
        chk("sync_valid", 32'(out_valid), 32'd1);
        chk("sync_data", 32'(out_data), 32'd0);
        chk("sync_err", 32'(out_err), 32'd0);
        chk("sync_cnt", 32'(err_cnt), 32'(exp_cnt));
        tick();

        // Saturation on the 2-bit counter, then clear coinciding with an increment
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_cnt2", 32'(err_cnt2), 32'd0);
        chk("clr_cnt8", 32'(err_cnt), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            send_cw(7'b1000101, 1'b0);
            chk($sformatf("sat_cnt2_%0d", k), 32'(err_cnt2), 32'((k > 3) ? 3 : k));
            chk($sformatf("sat_cnt8_%0d", k), 32'(err_cnt), 32'(k));
        end
        send_cw(7'b1000101, 1'b1);
        chk("clr_inc_cnt2", 32'(err_cnt2), 32'd1);
        chk("clr_inc_cnt8", 32'(err_cnt), 32'd1);
        tick();

        // Reset mid-codeword with a pending result
        out_ready = 1'b0;
        send_cw(7'b1000101, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(vecs[0].cw[i], 1'b0);
        chk("mid_pending_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_err", 32'(out_err), 32'd0);
        chk("mid_rst_syn", 32'(out_syn), 32'd0);
        chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
        chk("mid_rst_ready", 32'(ser_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send_cw(7'b1010101, 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'b1011);
        chk("post_rst_err", 32'(out_err), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
